// File: rtl/lut_cfg_pkg.sv
// rtl/lut_cfg_pkg.sv - shared state type and config-word field layout for the LUT4 config sequencer
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_STROBE,
        ST_INIT
    } state_t;

    localparam int CFG_BITS_DEFAULT = 19;

    // Bit positions inside one BEL config word, LSB shifted out first
    localparam int IDX_LUT_LO    = 0;
    localparam int IDX_LUT_HI    = 15;
    localparam int IDX_FF        = 16;
    localparam int IDX_I0MUX     = 17;
    localparam int IDX_RESET_VAL = 18;

endpackage

// File: rtl/lut_cfg_serializer.sv
// rtl/lut_cfg_serializer.sv - parallel-to-serial path for one BEL config word, LSB first
module lut_cfg_serializer
    import lut_cfg_pkg::*;
#(
    parameter int CFG_BITS = CFG_BITS_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic                i_shift,
    input  logic                i_clear,
    input  logic [CFG_BITS-1:0] i_data,
    output logic                o_bit,
    output logic                o_last
);

    localparam int               CNT_W    = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS - 1);

    logic [CFG_BITS-1:0] r_sreg;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_bit;
    logic                r_last;

    // r_bit is the bit currently on the wire; r_sreg holds the bits still to come
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_bit  <= 1'b0;
            r_last <= 1'b0;
        end else if (i_load) begin
            r_sreg <= i_data >> 1;
            r_bit  <= i_data[0];
            r_cnt  <= '0;
            r_last <= (CFG_BITS == 1);
        end else if (i_shift && !r_last) begin
            r_sreg <= r_sreg >> 1;
            r_bit  <= r_sreg[0];
            r_cnt  <= r_cnt + 1'b1;
            r_last <= ((r_cnt + 1'b1) == LAST_CNT);
        end else if (i_clear) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_bit  <= 1'b0;
            r_last <= 1'b0;
        end
    end

    assign o_bit  = r_bit;
    assign o_last = r_last;

endmodule

// File: rtl/lut_cfg_sequencer.sv
// rtl/lut_cfg_sequencer.sv - host-driven shift/strobe/init sequencer loading LUT4 BEL config words
module lut_cfg_sequencer
    import lut_cfg_pkg::*;
#(
    parameter int NUM_LUTS = 8,
    parameter int CFG_BITS = CFG_BITS_DEFAULT,
    parameter int ADDR_W   = 3
) (
    input  logic                UserCLK,
    input  logic                Reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    input  logic                cfg_init,
    output logic                frame_data,
    output logic                frame_shift,
    output logic [NUM_LUTS-1:0] frame_strobe,
    input  logic                lut_en_in,
    output logic                lut_en,
    output logic                lut_sr,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [NUM_LUTS-1:0] STROBE_ONE = NUM_LUTS'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_init;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_shift;
    logic [NUM_LUTS-1:0] r_strobe;
    logic                r_lut_en;
    logic                r_lut_sr;

    logic w_addr_ok;
    logic w_accept;
    logic w_load;
    logic w_shift;
    logic w_clear;
    logic w_bit;
    logic w_last;

    assign w_addr_ok = (32'(cfg_addr) < NUM_LUTS);
    assign w_accept  = (r_state == ST_IDLE) && cfg_valid;
    assign w_load    = w_accept && w_addr_ok;
    assign w_shift   = (r_state == ST_SHIFT) && !w_last;
    assign w_clear   = (r_state == ST_SHIFT) && w_last;

    lut_cfg_serializer #(
        .CFG_BITS (CFG_BITS)
    ) u_serializer (
        .i_clk   (UserCLK),
        .i_rst   (Reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_data  (cfg_data),
        .o_bit   (w_bit),
        .o_last  (w_last)
    );

    // Outputs are set for the state being entered so every port comes straight from a flop
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_init   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_shift  <= 1'b0;
            r_strobe <= '0;
            r_lut_en <= 1'b0;
            r_lut_sr <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_lut_en <= lut_en_in;
                    if (w_load) begin
                        r_addr   <= cfg_addr;
                        r_init   <= cfg_init;
                        r_state  <= ST_SHIFT;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_shift  <= 1'b1;
                        r_lut_en <= 1'b0;
                    end else if (w_accept) begin
                        r_err <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_state  <= ST_STROBE;
                        r_shift  <= 1'b0;
                        r_strobe <= STROBE_ONE << r_addr;
                    end
                end
                ST_STROBE: begin
                    r_strobe <= '0;
                    if (r_init) begin
                        r_state  <= ST_INIT;
                        r_lut_sr <= 1'b1;
                        r_lut_en <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_lut_en <= lut_en_in;
                    end
                end
                ST_INIT: begin
                    r_state  <= ST_IDLE;
                    r_lut_sr <= 1'b0;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_lut_en <= lut_en_in;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready    = r_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign frame_shift  = r_shift;
    assign frame_data   = w_bit;
    assign frame_strobe = r_strobe;
    assign lut_en       = r_lut_en;
    assign lut_sr       = r_lut_sr;

endmodule

// File: tb/tb_lut_cfg_sequencer.sv
// tb/tb_lut_cfg_sequencer.sv - self-checking bench for lut_cfg_sequencer (ADDR_W = 4 build)
module tb_lut_cfg_sequencer;

    logic        UserCLK = 1'b0;
    logic        Reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_addr = '0;
    logic [18:0] cfg_data = '0;
    logic        cfg_init = 1'b0;
    logic        frame_data;
    logic        frame_shift;
    logic [7:0]  frame_strobe;
    logic        lut_en_in = 1'b0;
    logic        lut_en;
    logic        lut_sr;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    lut_cfg_sequencer #(
        .NUM_LUTS (8),
        .CFG_BITS (19),
        .ADDR_W   (4)
    ) dut (
        .UserCLK      (UserCLK),
        .Reset        (Reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_init     (cfg_init),
        .frame_data   (frame_data),
        .frame_shift  (frame_shift),
        .frame_strobe (frame_strobe),
        .lut_en_in    (lut_en_in),
        .lut_en       (lut_en),
        .lut_sr       (lut_sr),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 UserCLK = ~UserCLK;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       err;
        logic       shift;
        logic       data;
        logic [7:0] strobe;
        logic       en;
        logic       sr;
    } obs_t;

    obs_t dut_obs;
    assign dut_obs = {cfg_ready, busy, done, err, frame_shift, frame_data, frame_strobe, lut_en, lut_sr};

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    // Model: on each accepted request, queue the whole expected output trace of the transaction
    obs_t m_q[$];
    obs_t m_cur = idle_obs();
    logic m_chk = 1'b0;

    always @(posedge UserCLK or posedge Reset) begin
        obs_t o;
        if (Reset) begin
            m_q.delete();
            m_cur = idle_obs();
            m_chk = 1'b0;
        end else begin
            if (m_cur.ready && cfg_valid) begin
                if (cfg_addr < 4'd8) begin
                    for (int k = 0; k < 19; k++) begin
                        o = '0;
                        o.busy = 1'b1;
                        o.shift = 1'b1;
                        o.data = cfg_data[k];
                        m_q.push_back(o);
                    end
                    o = '0;
                    o.busy = 1'b1;
                    o.strobe[cfg_addr[2:0]] = 1'b1;
                    m_q.push_back(o);
                    if (cfg_init) begin
                        o = '0;
                        o.busy = 1'b1;
                        o.en = 1'b1;
                        o.sr = 1'b1;
                        m_q.push_back(o);
                    end
                    o = idle_obs();
                    o.done = 1'b1;
                    m_q.push_back(o);
                end else begin
                    o = idle_obs();
                    o.err = 1'b1;
                    m_q.push_back(o);
                end
            end
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else m_cur = idle_obs();
            if (m_cur.ready) m_cur.en = lut_en_in;
            m_chk = 1'b1;
        end
    end

    always @(negedge UserCLK) begin
        if (!Reset && m_chk) begin
            n_cmp++;
            if (dut_obs !== m_cur) begin
                n_err++;
                $display("FAIL model_cycle t=%0t got rdy/busy/done/err/sh/d/strb/en/sr=%b/%b/%b/%b/%b/%b/%h/%b/%b expected %b/%b/%b/%b/%b/%b/%h/%b/%b",
                    $time, dut_obs.ready, dut_obs.busy, dut_obs.done, dut_obs.err, dut_obs.shift,
                    dut_obs.data, dut_obs.strobe, dut_obs.en, dut_obs.sr,
                    m_cur.ready, m_cur.busy, m_cur.done, m_cur.err, m_cur.shift,
                    m_cur.data, m_cur.strobe, m_cur.en, m_cur.sr);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [18:0] got_bits;
    int          nbits;
    int          strobe_cyc;
    logic [7:0]  strobe_val;
    int          init_cyc;
    logic        init_en;
    int          done_cyc;
    int          seen;

    task automatic run_req(input logic [3:0] a, input logic [18:0] d, input logic ini);
        @(negedge UserCLK);
        for (int i = 0; i < 50 && !cfg_ready; i++) @(negedge UserCLK);
        cfg_valid = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        cfg_init = ini;
        @(posedge UserCLK);
        #1 cfg_valid = 1'b0;
        got_bits = '0;
        nbits = 0;
        strobe_cyc = -1;
        strobe_val = '0;
        init_cyc = -1;
        init_en = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge UserCLK);
            if (frame_shift && nbits < 19) begin
                got_bits[nbits] = frame_data;
                nbits++;
            end
            if (frame_strobe != 8'h00) begin
                strobe_cyc = c;
                strobe_val = frame_strobe;
            end
            if (lut_sr) begin
                init_cyc = c;
                init_en = lut_en;
            end
            if (done) done_cyc = c;
        end
    endtask

    task automatic bad_req(input logic [3:0] a);
        @(negedge UserCLK);
        cfg_valid = 1'b1;
        cfg_addr = a;
        cfg_data = 19'h7FFFF;
        cfg_init = 1'b0;
        @(posedge UserCLK);
        #1 cfg_valid = 1'b0;
        @(negedge UserCLK);
        check("err_pulse", 32'(err), 32'(1));
        check("err_ready", 32'(cfg_ready), 32'(1));
        check("err_busy", 32'(busy), 32'(0));
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge UserCLK);
            lut_en_in = i[0];
            if (frame_shift || frame_strobe != 8'h00 || err || busy) seen++;
        end
        check("err_no_activity", 32'(seen), 32'(0));
        lut_en_in = 1'b0;
    endtask

    initial begin
        int c;

        repeat (3) @(negedge UserCLK);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_shift", 32'(frame_shift), 32'(0));
        check("rst_data", 32'(frame_data), 32'(0));
        check("rst_strobe", 32'(frame_strobe), 32'(0));
        check("rst_sr", 32'(lut_sr), 32'(0));
        Reset = 1'b0;

        run_req(4'd3, 19'h5A5A5, 1'b0);
        check("a3_bits", 32'(got_bits), 32'(19'h5A5A5));
        check("a3_nbits", 32'(nbits), 32'(19));
        check("a3_strobe_cyc", strobe_cyc, 32'(20));
        check("a3_strobe_val", 32'(strobe_val), 32'(8'b0000_1000));
        check("a3_init_cyc", init_cyc, 32'hFFFF_FFFF);
        check("a3_done_cyc", done_cyc, 32'(21));

        run_req(4'd0, 19'h4FFFF, 1'b1);
        check("a0_bits", 32'(got_bits), 32'(19'h4FFFF));
        check("a0_strobe_cyc", strobe_cyc, 32'(20));
        check("a0_strobe_val", 32'(strobe_val), 32'(8'b0000_0001));
        check("a0_init_cyc", init_cyc, 32'(21));
        check("a0_init_en", 32'(init_en), 32'(1));
        check("a0_done_cyc", done_cyc, 32'(22));

        run_req(4'd7, 19'h00003, 1'b0);
        check("a7_bits", 32'(got_bits), 32'(19'h00003));
        check("a7_strobe_val", 32'(strobe_val), 32'(8'b1000_0000));
        check("a7_done_cyc", done_cyc, 32'(21));

        bad_req(4'd9);
        bad_req(4'd8);

        // Back-to-back: the second request is held through the first one's busy window
        lut_en_in = 1'b1;
        @(negedge UserCLK);
        cfg_valid = 1'b1;
        cfg_addr = 4'd2;
        cfg_data = 19'h12345;
        cfg_init = 1'b0;
        @(posedge UserCLK);
        #1;
        cfg_addr = 4'd6;
        cfg_data = 19'h6789A;
        seen = 0;
        done_cyc = -1;
        for (c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge UserCLK);
            if (busy && lut_en) seen++;
            if (done) done_cyc = c;
        end
        check("b2b_first_done", done_cyc, 32'(21));
        check("b2b_ready_at_done", 32'(cfg_ready), 32'(1));
        @(posedge UserCLK);
        #1 cfg_valid = 1'b0;
        @(negedge UserCLK);
        check("b2b_second_accepted", 32'(busy), 32'(1));
        check("b2b_second_ready", 32'(cfg_ready), 32'(0));
        done_cyc = -1;
        strobe_val = '0;
        for (c = 2; c <= 40 && done_cyc < 0; c++) begin
            @(negedge UserCLK);
            if (busy && lut_en) seen++;
            if (frame_strobe != 8'h00) strobe_val = frame_strobe;
            if (done) done_cyc = c;
        end
        check("b2b_second_done", done_cyc, 32'(21));
        check("b2b_second_strobe", 32'(strobe_val), 32'(8'b0100_0000));
        check("b2b_en_low_busy", 32'(seen), 32'(0));

        // Reset in the middle of a shift sequence
        @(negedge UserCLK);
        cfg_valid = 1'b1;
        cfg_addr = 4'd5;
        cfg_data = 19'h2AAAA;
        cfg_init = 1'b1;
        @(posedge UserCLK);
        #1 cfg_valid = 1'b0;
        repeat (10) @(negedge UserCLK);
        check("rst_mid_in_shift", 32'(frame_shift), 32'(1));
        #1 Reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_shift", 32'(frame_shift), 32'(0));
        check("rst_mid_data", 32'(frame_data), 32'(0));
        seen = 0;
        repeat (3) begin
            @(negedge UserCLK);
            if (frame_strobe != 8'h00) seen++;
        end
        #1 Reset = 1'b0;
        repeat (25) begin
            @(negedge UserCLK);
            if (frame_strobe != 8'h00 || busy) seen++;
        end
        check("rst_mid_no_strobe", 32'(seen), 32'(0));

        run_req(4'd1, 19'h0F0F0, 1'b0);
        check("post_rst_bits", 32'(got_bits), 32'(19'h0F0F0));
        check("post_rst_strobe", 32'(strobe_val), 32'(8'b0000_0010));
        check("post_rst_done", done_cyc, 32'(21));

        repeat (3) @(negedge UserCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
